// File: rtl/key_debounce_mode_ctrl.sv
// Key conditioning front end: 2-flop sync, per-key debounce with press/release
// pulses, key0/key1 auto-repeat, and a registered pattern-mode selector.
module key_debounce_mode_ctrl #(
  parameter int unsigned N_KEYS          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned MODE_W          = 2,
  parameter int unsigned REPEAT_DELAY    = 13500000,
  parameter int unsigned REPEAT_PERIOD   = 5400000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_stable,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [1:0]        key_repeat,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [CNT_W-1:0]  db_cnt     [N_KEYS];
  logic [CNT_W-1:0]  db_cnt_nxt [N_KEYS];
  logic [N_KEYS-1:0] stable_nxt;
  logic [N_KEYS-1:0] press_nxt;
  logic [N_KEYS-1:0] release_nxt;

  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W-1:0]  rep_cnt_nxt;
  logic [REP_W-1:0]  rep_limit;
  logic              rep_armed;
  logic              rep_armed_nxt;
  logic              rep_run;
  logic              evt01;
  logic [1:0]        repeat_nxt;

  logic              step_up;
  logic              step_dn;
  logic [MODE_W-1:0] mode_nxt;
  logic              mode_changed_nxt;

  // Per-key debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    stable_nxt  = key_stable;
    press_nxt   = '0;
    release_nxt = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      db_cnt_nxt[i] = '0;
      if (sync2[i] != key_stable[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          stable_nxt[i]  = sync2[i];
          press_nxt[i]   = sync2[i];
          release_nxt[i] = ~sync2[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Shared auto-repeat timer; first interval is the delay, then the period.
  always_comb begin
    rep_cnt_nxt   = '0;
    rep_armed_nxt = 1'b0;
    repeat_nxt    = '0;
    evt01         = |(press_nxt[1:0] | release_nxt[1:0]);
    rep_run       = key_stable[0] ^ key_stable[1];
    rep_limit     = rep_armed ? PERIOD_LAST : DELAY_LAST;
    if (rep_run && !evt01) begin
      if (rep_cnt == rep_limit) begin
        repeat_nxt    = key_stable[1:0];
        rep_armed_nxt = 1'b1;
      end else begin
        rep_cnt_nxt   = rep_cnt + REP_W'(1);
        rep_armed_nxt = rep_armed;
      end
    end
  end

  // Mode stepping from the registered pulses; key7 clear wins over any step.
  always_comb begin
    step_up  = key_press[0] | key_repeat[0];
    step_dn  = key_press[1] | key_repeat[1];
    mode_nxt = mode;
    if (key_press[7]) begin
      mode_nxt = '0;
    end else if (step_up && !step_dn) begin
      mode_nxt = mode + MODE_W'(1);
    end else if (step_dn && !step_up) begin
      mode_nxt = mode - MODE_W'(1);
    end
    mode_changed_nxt = (mode_nxt != mode);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      key_stable   <= '0;
      key_press    <= '0;
      key_release  <= '0;
      key_repeat   <= '0;
      rep_cnt      <= '0;
      rep_armed    <= 1'b0;
      mode         <= '0;
      mode_changed <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1        <= key;
      sync2        <= sync1;
      key_stable   <= stable_nxt;
      key_press    <= press_nxt;
      key_release  <= release_nxt;
      key_repeat   <= repeat_nxt;
      rep_cnt      <= rep_cnt_nxt;
      rep_armed    <= rep_armed_nxt;
      mode         <= mode_nxt;
      mode_changed <= mode_changed_nxt;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_mode_ctrl.sv
// Bench for key_debounce_mode_ctrl: history-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_key_debounce_mode_ctrl;

  localparam int unsigned NK   = 8;
  localparam int unsigned DB   = 4;
  localparam int unsigned MW   = 2;
  localparam int unsigned RD   = 20;
  localparam int unsigned RP   = 8;
  localparam int          MAXC = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key   = '0;
  logic [NK-1:0] key_stable;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [1:0]    key_repeat;
  logic [MW-1:0] mode;
  logic          mode_changed;

  key_debounce_mode_ctrl #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .MODE_W(MW),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .key(key),
    .key_stable(key_stable), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .mode(mode), .mode_changed(mode_changed)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Reference state: raw input history plus expected outputs after each edge.
  logic [NK-1:0] key_at [MAXC];
  bit            rst_at [MAXC];
  logic [NK-1:0] m_stable, m_press, m_release;
  logic [1:0]    m_rep;
  logic [MW-1:0] m_mode;
  logic          m_mc;
  int            last_flip [NK];
  int            last01;
  bit            valid = 1'b0;

  // Observed DUT activity for the directed literal checks.
  int n_press0 = 0, n_rep = 0, n_mc = 0;
  int last_press0 = -1, last_press3 = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Level the debounce logic acts on at edge t: key sampled two edges earlier,
  // zero if a reset wiped the synchronizer in between.
  function automatic logic [NK-1:0] used_at(input int t);
    if (t < 2) return '0;
    if (rst_at[t-1] || rst_at[t-2]) return '0;
    return key_at[t-2];
  endfunction

  always @(posedge clock) begin : model
    logic [NK-1:0] os, flip, uv;
    logic          up, dn, p7, ok, fire;
    logic [MW-1:0] nm;
    int            t, k;
    edge_n++;
    t = edge_n;
    if (t >= MAXC) begin
      $display("FAIL history_overflow: edge %0d limit %0d", t, MAXC);
      $fatal(1);
    end
    key_at[t] = key;
    rst_at[t] = reset;
    if (reset) begin
      m_stable = '0; m_press = '0; m_release = '0; m_rep = '0;
      m_mode = '0; m_mc = 1'b0; last01 = t; valid = 1'b1;
      for (int i = 0; i < NK; i++) last_flip[i] = t;
    end else begin
      os = m_stable;
      up = m_press[0] | m_rep[0];
      dn = m_press[1] | m_rep[1];
      p7 = m_press[7];
      // A level is accepted once the last DB decision samples since the previous
      // change all disagree with the current stable level.
      flip = '0;
      for (int i = 0; i < NK; i++) begin
        if (t - last_flip[i] >= DB) begin
          ok = 1'b1;
          for (int u = t - DB + 1; u <= t; u++) begin
            uv = used_at(u);
            if (uv[i] == os[i]) ok = 1'b0;
          end
          flip[i] = ok;
        end
      end
      for (int i = 0; i < NK; i++) if (flip[i]) last_flip[i] = t;
      m_press   = flip & ~os;
      m_release = flip & os;
      m_stable  = os ^ flip;
      k    = t - last01;
      fire = (os[0] ^ os[1]) && !(flip[0] | flip[1]) && (k >= RD) && (((k - RD) % RP) == 0);
      m_rep = fire ? os[1:0] : 2'b00;
      if (flip[1:0] != 2'b00) last01 = t;
      nm = m_mode;
      if (p7) nm = '0;
      else if (up && !dn) nm = m_mode + MW'(1);
      else if (dn && !up) nm = m_mode - MW'(1);
      m_mc   = (nm != m_mode);
      m_mode = nm;
    end
    #1;
    if (valid) begin
      check("key_stable", 32'(key_stable), 32'(m_stable));
      check("key_press", 32'(key_press), 32'(m_press));
      check("key_release", 32'(key_release), 32'(m_release));
      check("key_repeat", 32'(key_repeat), 32'(m_rep));
      check("mode", 32'(mode), 32'(m_mode));
      check("mode_changed", 32'(mode_changed), 32'(m_mc));
      if (key_press[0] === 1'b1) begin n_press0++; last_press0 = edge_n; end
      if (key_press[3] === 1'b1) last_press3 = edge_n;
      if (key_repeat !== 2'b00) n_rep++;
      if (mode_changed === 1'b1) n_mc++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tap(input int b);
    key[b] = 1'b1; cyc(8);
    key[b] = 1'b0; cyc(8);
  endtask

  int s, bp, bm, br;

  initial begin
    cyc(3);
    check("reset_stable", 32'(key_stable), 32'h0);
    check("reset_mode", 32'(mode), 32'h0);
    check("reset_repeat", 32'(key_repeat), 32'h0);
    reset = 1'b0;
    cyc(2);

    // Bounce then hold on key0
    bp = n_press0; bm = n_mc;
    key[0] = 1'b1; cyc(3);
    key[0] = 1'b0; cyc(2);
    check("bounce_no_press", 32'(n_press0 - bp), 32'd0);
    key[0] = 1'b1; s = edge_n + 1; cyc(10);
    check("bounce_press_count", 32'(n_press0 - bp), 32'd1);
    check("bounce_press_edge", 32'(last_press0), 32'(s + 5));
    check("bounce_mode", 32'(mode), 32'd1);
    check("bounce_mc_count", 32'(n_mc - bm), 32'd1);
    key[0] = 1'b0; cyc(10);

    // Wrap up and down
    bm = n_mc;
    tap(0); check("wrap_m2", 32'(mode), 32'd2);
    tap(0); check("wrap_m3", 32'(mode), 32'd3);
    tap(0); check("wrap_m0", 32'(mode), 32'd0);
    tap(0); check("wrap_m1", 32'(mode), 32'd1);
    tap(1); check("wrap_dn0", 32'(mode), 32'd0);
    tap(1); check("wrap_dn3", 32'(mode), 32'd3);
    check("wrap_mc_count", 32'(n_mc - bm), 32'd6);

    // Simultaneous key0 and key1
    bm = n_mc; bp = n_press0;
    key[1:0] = 2'b11; cyc(8);
    check("simul_mode", 32'(mode), 32'd3);
    check("simul_mc", 32'(n_mc - bm), 32'd0);
    check("simul_press0", 32'(n_press0 - bp), 32'd1);
    key[1:0] = 2'b00; cyc(8);

    // key7 priority over key0, then key7 at mode 0
    tap(1); check("prio_setup", 32'(mode), 32'd2);
    bm = n_mc;
    key[7] = 1'b1; key[0] = 1'b1; cyc(8);
    check("prio_mode", 32'(mode), 32'd0);
    check("prio_mc", 32'(n_mc - bm), 32'd1);
    key[7] = 1'b0; key[0] = 1'b0; cyc(8);
    bm = n_mc;
    tap(7);
    check("clear_at0_mc", 32'(n_mc - bm), 32'd0);
    check("clear_at0_mode", 32'(mode), 32'd0);

    // Auto-repeat on a long key0 hold
    br = n_rep;
    key[0] = 1'b1; cyc(60);
    key[0] = 1'b0; cyc(10);
    check("repeat_count", 32'(n_rep - br), 32'd5);
    check("repeat_mode", 32'(mode), 32'd2);
    br = n_rep;
    key[1:0] = 2'b11; cyc(40);
    check("repeat_both_none", 32'(n_rep - br), 32'd0);
    key[1:0] = 2'b00; cyc(10);
    check("repeat_both_mode", 32'(mode), 32'd2);

    // Reset in the middle of a key3 debounce
    key[3] = 1'b1; cyc(2);
    reset = 1'b1; cyc(1);
    check("rst_stable3", 32'(key_stable[3]), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    reset = 1'b0; s = edge_n + 1; cyc(10);
    check("rst_press3_edge", 32'(last_press3), 32'(s + 5));
    check("rst_stable3_after", 32'(key_stable[3]), 32'd1);
    check("rst_mode_after", 32'(mode), 32'd0);
    key[3] = 1'b0; cyc(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
